// File: rtl/nasti_lite_writer.sv
// nasti_lite_writer: replays one NASTI write burst as a sequence of single-beat
// NASTI-Lite writes and merges the Lite responses into one NASTI B response.
module nasti_lite_writer #(
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  // master-facing NASTI AW
  input  logic [ID_WIDTH-1:0]     master_aw_id,
  input  logic [ADDR_WIDTH-1:0]   master_aw_addr,
  input  logic [7:0]              master_aw_len,
  input  logic [2:0]              master_aw_size,
  input  logic [1:0]              master_aw_burst,
  input  logic [2:0]              master_aw_prot,
  input  logic [USER_WIDTH-1:0]   master_aw_user,
  input  logic                    master_aw_valid,
  output logic                    master_aw_ready,
  // master-facing NASTI W
  input  logic [DATA_WIDTH-1:0]   master_w_data,
  input  logic [DATA_WIDTH/8-1:0] master_w_strb,
  input  logic                    master_w_last,
  input  logic                    master_w_valid,
  output logic                    master_w_ready,
  // master-facing NASTI B
  output logic [ID_WIDTH-1:0]     master_b_id,
  output logic [1:0]              master_b_resp,
  output logic [USER_WIDTH-1:0]   master_b_user,
  output logic                    master_b_valid,
  input  logic                    master_b_ready,
  // Lite AW
  output logic [ADDR_WIDTH-1:0]   lite_aw_addr,
  output logic [2:0]              lite_aw_prot,
  output logic                    lite_aw_valid,
  input  logic                    lite_aw_ready,
  // Lite W
  output logic [DATA_WIDTH-1:0]   lite_w_data,
  output logic [DATA_WIDTH/8-1:0] lite_w_strb,
  output logic                    lite_w_valid,
  input  logic                    lite_w_ready,
  // Lite B
  input  logic [1:0]              lite_b_resp,
  input  logic                    lite_b_valid,
  output logic                    lite_b_ready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_WIDTH));

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT,
    S_WAITB,
    S_RESP
  } state_t;

  state_t                  state_reg, state_next;
  logic [ID_WIDTH-1:0]     id_reg, id_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [7:0]              len_reg, len_next;
  logic [2:0]              size_reg, size_next;
  logic [1:0]              burst_reg, burst_next;
  logic [2:0]              prot_reg, prot_next;
  logic [USER_WIDTH-1:0]   user_reg, user_next;
  logic [7:0]              cnt_reg, cnt_next;
  logic [1:0]              resp_reg, resp_next;
  logic                    aw_sent_reg, aw_sent_next;
  logic                    w_sent_reg, w_sent_next;

  logic [ADDR_WIDTH-1:0]   beat_bytes;
  logic [ADDR_WIDTH-1:0]   addr_step;
  logic                    is_last_beat;

  // Next beat address: FIXED stays put, everything else aligns down then advances one beat.
  assign beat_bytes   = ADDR_WIDTH'(1) << size_reg;
  assign addr_step    = (burst_reg == 2'b00) ? addr_reg
                                             : ((addr_reg & ~(beat_bytes - ADDR_WIDTH'(1))) + beat_bytes);
  assign is_last_beat = (cnt_reg == len_reg);

  assign lite_aw_addr  = addr_reg;
  assign lite_aw_prot  = prot_reg;
  assign master_b_id   = id_reg;
  assign master_b_resp = resp_reg;
  assign master_b_user = user_reg;

  // Beat data and strobes go straight through, one byte lane at a time.
  generate
    for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
      assign lite_w_data[gi*8 +: 8] = master_w_data[gi*8 +: 8];
      assign lite_w_strb[gi]        = master_w_strb[gi];
    end
  endgenerate

  // State and burst context registers; reset drops any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      id_reg      <= '0;
      addr_reg    <= '0;
      len_reg     <= '0;
      size_reg    <= '0;
      burst_reg   <= '0;
      prot_reg    <= '0;
      user_reg    <= '0;
      cnt_reg     <= '0;
      resp_reg    <= '0;
      aw_sent_reg <= 1'b0;
      w_sent_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      id_reg      <= id_next;
      addr_reg    <= addr_next;
      len_reg     <= len_next;
      size_reg    <= size_next;
      burst_reg   <= burst_next;
      prot_reg    <= prot_next;
      user_reg    <= user_next;
      cnt_reg     <= cnt_next;
      resp_reg    <= resp_next;
      aw_sent_reg <= aw_sent_next;
      w_sent_reg  <= w_sent_next;
    end
  end

  // Next-state, handshake decode and response merging.
  always_comb begin
    state_next      = state_reg;
    id_next         = id_reg;
    addr_next       = addr_reg;
    len_next        = len_reg;
    size_next       = size_reg;
    burst_next      = burst_reg;
    prot_next       = prot_reg;
    user_next       = user_reg;
    cnt_next        = cnt_reg;
    resp_next       = resp_reg;
    aw_sent_next    = aw_sent_reg;
    w_sent_next     = w_sent_reg;
    master_aw_ready = 1'b0;
    master_w_ready  = 1'b0;
    master_b_valid  = 1'b0;
    lite_aw_valid   = 1'b0;
    lite_w_valid    = 1'b0;
    lite_b_ready    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        master_aw_ready = 1'b1;
        if (master_aw_valid) begin
          id_next      = master_aw_id;
          addr_next    = master_aw_addr;
          len_next     = master_aw_len;
          size_next    = master_aw_size;
          burst_next   = master_aw_burst;
          prot_next    = master_aw_prot;
          user_next    = master_aw_user;
          cnt_next     = '0;
          resp_next    = 2'b00;
          aw_sent_next = 1'b0;
          w_sent_next  = 1'b0;
          state_next   = S_BEAT;
        end
      end

      S_BEAT: begin
        lite_aw_valid  = !aw_sent_reg;
        lite_w_valid   = !w_sent_reg && master_w_valid;
        master_w_ready = !w_sent_reg && lite_w_ready;
        if (lite_aw_valid && lite_aw_ready) begin
          aw_sent_next = 1'b1;
        end
        if (lite_w_valid && lite_w_ready) begin
          w_sent_next = 1'b1;
          // A misplaced last marker is reported, but the beat still goes out.
          if ((master_w_last != is_last_beat) && (resp_reg == 2'b00)) begin
            resp_next = 2'b10;
          end
        end
        if (aw_sent_next && w_sent_next) begin
          state_next = S_WAITB;
        end
      end

      S_WAITB: begin
        lite_b_ready = 1'b1;
        if (lite_b_valid) begin
          // First non-OKAY response sticks for the rest of the burst.
          if (resp_reg == 2'b00) begin
            resp_next = lite_b_resp;
          end
          if (is_last_beat) begin
            state_next = S_RESP;
          end else begin
            cnt_next     = cnt_reg + 8'd1;
            aw_sent_next = 1'b0;
            w_sent_next  = 1'b0;
            addr_next    = addr_step;
            state_next   = S_BEAT;
          end
        end
      end

      S_RESP: begin
        master_b_valid = 1'b1;
        if (master_b_ready) begin
          state_next = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // Beats wider than the data bus cannot be represented here.
  a_size_legal: assert property (@(posedge clk) disable iff (rst)
    (master_aw_valid && master_aw_ready) |-> (master_aw_size <= MAX_SIZE));

endmodule

// File: tb/tb_nasti_lite_writer.sv
// tb_nasti_lite_writer: directed tests for the burst-to-Lite write replayer.
module tb_nasti_lite_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [1:0]  master_aw_id = '0;
  logic [31:0] master_aw_addr = '0;
  logic [7:0]  master_aw_len = '0;
  logic [2:0]  master_aw_size = '0;
  logic [1:0]  master_aw_burst = '0;
  logic [2:0]  master_aw_prot = '0;
  logic [0:0]  master_aw_user = '0;
  logic        master_aw_valid = 1'b0;
  logic        master_aw_ready;
  logic [31:0] master_w_data = '0;
  logic [3:0]  master_w_strb = '0;
  logic        master_w_last = 1'b0;
  logic        master_w_valid = 1'b0;
  logic        master_w_ready;
  logic [1:0]  master_b_id;
  logic [1:0]  master_b_resp;
  logic [0:0]  master_b_user;
  logic        master_b_valid;
  logic        master_b_ready = 1'b0;
  logic [31:0] lite_aw_addr;
  logic [2:0]  lite_aw_prot;
  logic        lite_aw_valid;
  logic        lite_aw_ready = 1'b0;
  logic [31:0] lite_w_data;
  logic [3:0]  lite_w_strb;
  logic        lite_w_valid;
  logic        lite_w_ready = 1'b0;
  logic [1:0]  lite_b_resp = '0;
  logic        lite_b_valid = 1'b0;
  logic        lite_b_ready;

  int total = 0;
  int bad = 0;

  // knobs for the burst driver
  logic [31:0] data_tab [16];
  logic [3:0]  strb_tab [16];
  logic [1:0]  resp_tab [16];
  int aw_stall, b_hold, bad_last, abort_after_b;

  // records from the burst driver
  logic [31:0] rec_addr [16];
  logic [2:0]  rec_prot [16];
  logic [31:0] rec_data [16];
  logic [3:0]  rec_strb [16];
  int n_aw, n_w, n_b_lite;
  bit got_b;
  logic [1:0] b_resp, b_id;
  logic [0:0] b_user;
  int w_in_stall, w_overrun, b_unstable, b_hold_seen;

  always #5 clk = ~clk;

  nasti_lite_writer #(
    .ID_WIDTH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_WIDTH(1)
  ) dut (
    .clk(clk), .rst(rst),
    .master_aw_id(master_aw_id), .master_aw_addr(master_aw_addr),
    .master_aw_len(master_aw_len), .master_aw_size(master_aw_size),
    .master_aw_burst(master_aw_burst), .master_aw_prot(master_aw_prot),
    .master_aw_user(master_aw_user), .master_aw_valid(master_aw_valid),
    .master_aw_ready(master_aw_ready),
    .master_w_data(master_w_data), .master_w_strb(master_w_strb),
    .master_w_last(master_w_last), .master_w_valid(master_w_valid),
    .master_w_ready(master_w_ready),
    .master_b_id(master_b_id), .master_b_resp(master_b_resp),
    .master_b_user(master_b_user), .master_b_valid(master_b_valid),
    .master_b_ready(master_b_ready),
    .lite_aw_addr(lite_aw_addr), .lite_aw_prot(lite_aw_prot),
    .lite_aw_valid(lite_aw_valid), .lite_aw_ready(lite_aw_ready),
    .lite_w_data(lite_w_data), .lite_w_strb(lite_w_strb),
    .lite_w_valid(lite_w_valid), .lite_w_ready(lite_w_ready),
    .lite_b_resp(lite_b_resp), .lite_b_valid(lite_b_valid),
    .lite_b_ready(lite_b_ready)
  );

  task automatic reset_knobs();
    for (int i = 0; i < 16; i++) begin
      data_tab[i] = 32'hCAFE_0000 + 32'(i) * 32'h0101;
      strb_tab[i] = 4'hF;
      resp_tab[i] = 2'b00;
    end
    aw_stall = 0;
    b_hold = 0;
    bad_last = -1;
    abort_after_b = 0;
  endtask

  // Acts as NASTI master and Lite slave for one burst; inputs change at negedge,
  // outputs are sampled 1 time unit later, handshakes complete at the next posedge.
  task automatic run_burst(input logic [1:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [2:0] prot, input logic [0:0] user);
    int w_idx = 0;
    int stall_seen = 0;
    int hold_seen = 0;
    bit b_seen = 0;
    bit aw_pending = 1;
    logic [1:0] cap_resp = '0;
    logic [1:0] cap_id = '0;
    logic [0:0] cap_user = '0;
    n_aw = 0; n_w = 0; n_b_lite = 0; got_b = 0;
    w_in_stall = 0; w_overrun = 0; b_unstable = 0; b_hold_seen = 0;
    @(negedge clk);
    master_aw_id = id; master_aw_addr = addr; master_aw_len = 8'(len);
    master_aw_size = size; master_aw_burst = burst;
    master_aw_prot = prot; master_aw_user = user;
    for (int cyc = 0; cyc < 400 && !got_b; cyc++) begin
      master_aw_valid = aw_pending;
      master_w_valid  = (w_idx <= len);
      master_w_data   = data_tab[w_idx % 16];
      master_w_strb   = strb_tab[w_idx % 16];
      master_w_last   = (w_idx == ((bad_last >= 0) ? bad_last : len));
      lite_aw_ready   = !(n_aw == 0 && stall_seen < aw_stall);
      lite_w_ready    = 1'b1;
      lite_b_valid    = (n_aw > n_b_lite) && (n_w > n_b_lite);
      lite_b_resp     = resp_tab[n_b_lite % 16];
      master_b_ready  = (hold_seen >= b_hold);
      #1;
      if (master_aw_valid && master_aw_ready) aw_pending = 0;
      if (master_w_valid && master_w_ready) w_idx++;
      if (lite_aw_valid && !lite_aw_ready && n_aw == 0) stall_seen++;
      if (lite_w_valid && lite_w_ready) begin
        if (n_w != n_b_lite) w_overrun++;
        if (n_aw == 0 && !lite_aw_ready) w_in_stall++;
        rec_data[n_w % 16] = lite_w_data;
        rec_strb[n_w % 16] = lite_w_strb;
        n_w++;
      end
      if (lite_aw_valid && lite_aw_ready) begin
        rec_addr[n_aw % 16] = lite_aw_addr;
        rec_prot[n_aw % 16] = lite_aw_prot;
        n_aw++;
      end
      if (lite_b_ready && lite_b_valid) n_b_lite++;
      if (master_b_valid) begin
        if (!b_seen) begin
          b_seen = 1; cap_resp = master_b_resp; cap_id = master_b_id; cap_user = master_b_user;
        end else if (master_b_resp !== cap_resp || master_b_id !== cap_id || master_b_user !== cap_user) begin
          b_unstable++;
        end
        if (master_aw_ready !== 1'b0) b_unstable++;
        if (master_b_ready) begin
          got_b = 1; b_resp = master_b_resp; b_id = master_b_id; b_user = master_b_user;
          $display("burst addr=%h len=%0d id=%0d -> lite_writes=%0d b_resp=%b b_id=%0d b_user=%0d",
                   addr, len, id, n_w, b_resp, b_id, b_user);
        end else begin
          hold_seen++;
        end
      end
      if (abort_after_b > 0 && n_b_lite >= abort_after_b) break;
      @(negedge clk);
    end
    b_hold_seen = hold_seen;
    master_aw_valid = 0; master_w_valid = 0; master_w_last = 0;
    lite_b_valid = 0; master_b_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (master_aw_ready !== 1'b1) begin bad++; $display("FAIL reset_aw_ready: got %b want 1", master_aw_ready); end
    total++; if ({lite_aw_valid, lite_w_valid, lite_b_ready, master_b_valid} !== 4'b0000) begin
      bad++; $display("FAIL reset_valids: got %b want 0000", {lite_aw_valid, lite_w_valid, lite_b_ready, master_b_valid}); end
    total++; if ({master_b_id, master_b_resp, master_b_user} !== 5'b0) begin
      bad++; $display("FAIL reset_b_fields: got %b want 00000", {master_b_id, master_b_resp, master_b_user}); end
    @(negedge clk);
    rst = 1'b0;
    lite_aw_ready = 1'b1; lite_w_ready = 1'b1;
    $display("reset released");
  endtask

  task automatic test_incr();
    logic [31:0] exp_addr [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    logic [31:0] exp_data [4] = '{32'hDEAD_0001, 32'hBEEF_0002, 32'h1234_5678, 32'h0F0F_0F0F};
    logic [3:0]  exp_strb [4] = '{4'hF, 4'h3, 4'hC, 4'h1};
    reset_knobs();
    for (int i = 0; i < 4; i++) begin data_tab[i] = exp_data[i]; strb_tab[i] = exp_strb[i]; end
    run_burst(2'd2, 32'h1000, 3, 3'd2, 2'b01, 3'b101, 1'b1);
    total++; if (got_b !== 1'b1) begin bad++; $display("FAIL incr_got_b: got %b want 1", got_b); end
    total++; if (n_aw !== 4) begin bad++; $display("FAIL incr_n_aw: got %0d want 4", n_aw); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rec_addr[i] !== exp_addr[i]) begin bad++; $display("FAIL incr_addr[%0d]: got %h want %h", i, rec_addr[i], exp_addr[i]); end
      total++; if (rec_data[i] !== exp_data[i] || rec_strb[i] !== exp_strb[i]) begin
        bad++; $display("FAIL incr_data[%0d]: got %h/%h want %h/%h", i, rec_data[i], rec_strb[i], exp_data[i], exp_strb[i]); end
      total++; if (rec_prot[i] !== 3'b101) begin bad++; $display("FAIL incr_prot[%0d]: got %b want 101", i, rec_prot[i]); end
    end
    total++; if (b_resp !== 2'b00 || b_id !== 2'd2 || b_user !== 1'b1) begin
      bad++; $display("FAIL incr_b: got resp=%b id=%0d user=%0d want resp=00 id=2 user=1", b_resp, b_id, b_user); end
  endtask

  task automatic test_unaligned();
    reset_knobs();
    run_burst(2'd1, 32'h1002, 1, 3'd2, 2'b01, 3'b000, 1'b0);
    total++; if (n_aw !== 2 || rec_addr[0] !== 32'h1002 || rec_addr[1] !== 32'h1004) begin
      bad++; $display("FAIL unaligned_addr: got n=%0d %h %h want n=2 00001002 00001004", n_aw, rec_addr[0], rec_addr[1]); end
    total++; if (b_resp !== 2'b00 || b_id !== 2'd1) begin bad++; $display("FAIL unaligned_b: got %b/%0d want 00/1", b_resp, b_id); end
    // address wraps past the top of the space; burst type 11 behaves as INCR
    reset_knobs();
    run_burst(2'd3, 32'hFFFF_FFFE, 1, 3'd2, 2'b11, 3'b000, 1'b0);
    total++; if (rec_addr[0] !== 32'hFFFF_FFFE || rec_addr[1] !== 32'h0000_0000) begin
      bad++; $display("FAIL wrap_addr: got %h %h want fffffffe 00000000", rec_addr[0], rec_addr[1]); end
    // byte-sized beats step by one
    reset_knobs();
    run_burst(2'd0, 32'h0000_0007, 1, 3'd0, 2'b01, 3'b000, 1'b0);
    total++; if (rec_addr[0] !== 32'h7 || rec_addr[1] !== 32'h8) begin
      bad++; $display("FAIL size0_addr: got %h %h want 00000007 00000008", rec_addr[0], rec_addr[1]); end
  endtask

  task automatic test_fixed();
    reset_knobs();
    run_burst(2'd0, 32'h20, 2, 3'd2, 2'b00, 3'b010, 1'b0);
    total++; if (n_aw !== 3 || n_w !== 3) begin bad++; $display("FAIL fixed_count: got aw=%0d w=%0d want 3/3", n_aw, n_w); end
    for (int i = 0; i < 3; i++) begin
      total++; if (rec_addr[i] !== 32'h20) begin bad++; $display("FAIL fixed_addr[%0d]: got %h want 00000020", i, rec_addr[i]); end
    end
    total++; if (rec_data[2] !== 32'hCAFE_0202) begin bad++; $display("FAIL fixed_data2: got %h want cafe0202", rec_data[2]); end
  endtask

  task automatic test_resp_merge();
    reset_knobs();
    resp_tab[0] = 2'b00; resp_tab[1] = 2'b10; resp_tab[2] = 2'b11;
    run_burst(2'd1, 32'h2000, 2, 3'd2, 2'b01, 3'b000, 1'b1);
    total++; if (b_resp !== 2'b10 || n_w !== 3) begin bad++; $display("FAIL merge_resp: got %b w=%0d want 10 w=3", b_resp, n_w); end
    reset_knobs();
    resp_tab[1] = 2'b11;
    run_burst(2'd1, 32'h2000, 2, 3'd2, 2'b01, 3'b000, 1'b1);
    total++; if (b_resp !== 2'b11) begin bad++; $display("FAIL merge_decerr: got %b want 11", b_resp); end
    reset_knobs();
    bad_last = 1;
    run_burst(2'd3, 32'h2100, 3, 3'd2, 2'b01, 3'b000, 1'b0);
    total++; if (b_resp !== 2'b10) begin bad++; $display("FAIL early_last_resp: got %b want 10", b_resp); end
    total++; if (n_w !== 4 || n_aw !== 4) begin bad++; $display("FAIL early_last_beats: got w=%0d aw=%0d want 4/4", n_w, n_aw); end
  endtask

  task automatic test_backpressure();
    reset_knobs();
    aw_stall = 3;
    b_hold = 5;
    run_burst(2'd1, 32'h5000, 1, 3'd2, 2'b01, 3'b000, 1'b1);
    total++; if (w_in_stall !== 1) begin bad++; $display("FAIL bp_w_during_stall: got %0d want 1", w_in_stall); end
    total++; if (w_overrun !== 0) begin bad++; $display("FAIL bp_w_before_b: got %0d want 0", w_overrun); end
    total++; if (b_hold_seen !== 5 || b_unstable !== 0) begin
      bad++; $display("FAIL bp_b_hold: got held=%0d unstable=%0d want 5/0", b_hold_seen, b_unstable); end
    total++; if (got_b !== 1'b1 || b_resp !== 2'b00 || b_id !== 2'd1 || rec_addr[1] !== 32'h5004) begin
      bad++; $display("FAIL bp_result: got b=%b resp=%b id=%0d addr1=%h want 1/00/1/00005004", got_b, b_resp, b_id, rec_addr[1]); end
  endtask

  task automatic test_reset_mid();
    reset_knobs();
    abort_after_b = 2;
    run_burst(2'd2, 32'h3000, 3, 3'd2, 2'b01, 3'b000, 1'b1);
    total++; if (n_w !== 2) begin bad++; $display("FAIL midrst_beats: got %0d want 2", n_w); end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if ({lite_aw_valid, lite_w_valid, master_b_valid, master_aw_ready} !== 4'b0001) begin
        bad++; $display("FAIL midrst_outputs[%0d]: got %b want 0001", k, {lite_aw_valid, lite_w_valid, master_b_valid, master_aw_ready}); end
      @(negedge clk);
    end
    rst = 1'b0;
    reset_knobs();
    run_burst(2'd3, 32'h4000, 1, 3'd2, 2'b01, 3'b000, 1'b0);
    total++; if (got_b !== 1'b1 || b_resp !== 2'b00 || b_id !== 2'd3 || rec_addr[0] !== 32'h4000 || rec_addr[1] !== 32'h4004) begin
      bad++; $display("FAIL midrst_fresh: got b=%b resp=%b id=%0d %h %h want 1/00/3/00004000/00004004",
                      got_b, b_resp, b_id, rec_addr[0], rec_addr[1]); end
  endtask

  initial begin
    reset_knobs();
    test_reset();
    test_incr();
    test_unaligned();
    test_fixed();
    test_resp_merge();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
